// File: rtl/program_memory_arbiter_if.sv
// rtl/program_memory_arbiter_if.sv - fetch, loader and program-memory signal bundle for program_memory_arbiter
// slave modport is the arbiter's view; master is the fetch stage, loader and memory array side.
interface program_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5
);
    logic                  fetch_req_i;
    logic [DATA_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_rvalid_o;
    logic [DATA_WIDTH-1:0] fetch_rdata_o;

    logic                  load_req_i;
    logic                  load_we_i;
    logic [DATA_WIDTH-1:0] load_addr_i;
    logic [DATA_WIDTH-1:0] load_wdata_i;
    logic                  load_gnt_o;
    logic                  load_rvalid_o;
    logic [DATA_WIDTH-1:0] load_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  addr_err_o;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        input  load_req_i, load_we_i, load_addr_i, load_wdata_i,
        input  mem_rdata_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        output load_gnt_o, load_rvalid_o, load_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output addr_err_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        output load_req_i, load_we_i, load_addr_i, load_wdata_i,
        output mem_rdata_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        input  load_gnt_o, load_rvalid_o, load_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  addr_err_o
    );
endinterface

// File: rtl/program_memory_arbiter.sv
// rtl/program_memory_arbiter.sv - fetch/loader arbiter for a single-port program memory
// Optional ARB_PERF_CNT_EN adds saturating fetch-stall and loader-grant counters.
module program_memory_arbiter #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    ADDR_W       = $clog2(MEMORY_DEPTH),
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter int                    LOAD_BURST   = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    program_memory_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_stall_o,
    output logic [31:0]              perf_load_gnt_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] TEXT_END   = TEXT_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH);
    localparam logic [3:0]            BURST_MAX  = 4'(LOAD_BURST);

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_FETCH,
        RSP_LOAD
    } rsp_owner_t;

    rsp_owner_t rsp_owner_q, rsp_owner_d;
    logic       rsp_illegal_q, rsp_illegal_d;
    logic       rsp_we_q, rsp_we_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       addr_err_q, addr_err_d;

    logic                  fetch_legal, load_legal;
    logic [DATA_WIDTH-1:0] fetch_off, load_off;
    logic [ADDR_W-1:0]     fetch_idx, load_idx;
    logic                  fetch_gnt, load_gnt;

    function automatic logic addr_legal(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= TEXT_BASE) && (addr < TEXT_END);
    endfunction

    // Offsets below TEXT_BASE wrap to huge values; the range check rejects them.
    always_comb begin
        fetch_off   = bus.fetch_addr_i - TEXT_BASE;
        load_off    = bus.load_addr_i - TEXT_BASE;
        fetch_idx   = ADDR_W'(fetch_off >> 2);
        load_idx    = ADDR_W'(load_off >> 2);
        fetch_legal = addr_legal(bus.fetch_addr_i);
        load_legal  = addr_legal(bus.load_addr_i);
    end

    // Loader wins unless it has already taken LOAD_BURST grants while fetch waited.
    // Grants are gated by reset so a reset landing in a grant cycle suppresses the access.
    always_comb begin
        fetch_gnt = reset && bus.fetch_req_i &&
                    (!bus.load_req_i || (burst_cnt_q >= BURST_MAX));
        load_gnt  = reset && bus.load_req_i && !fetch_gnt;
    end

    always_comb begin
        bus.fetch_gnt_o = fetch_gnt;
        bus.load_gnt_o  = load_gnt;
        bus.mem_en_o    = (fetch_gnt && fetch_legal) || (load_gnt && load_legal);
        bus.mem_we_o    = load_gnt && load_legal && bus.load_we_i;
        bus.mem_addr_o  = '0;
        if (fetch_gnt && fetch_legal) begin
            bus.mem_addr_o = fetch_idx;
        end else if (load_gnt && load_legal) begin
            bus.mem_addr_o = load_idx;
        end
        bus.mem_wdata_o = (load_gnt && load_legal && bus.load_we_i) ? bus.load_wdata_i : '0;
    end

    always_comb begin
        rsp_owner_d   = RSP_NONE;
        rsp_illegal_d = 1'b0;
        rsp_we_d      = 1'b0;
        if (fetch_gnt) begin
            rsp_owner_d   = RSP_FETCH;
            rsp_illegal_d = !fetch_legal;
        end else if (load_gnt) begin
            rsp_owner_d   = RSP_LOAD;
            rsp_illegal_d = !load_legal;
            rsp_we_d      = bus.load_we_i;
        end
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!bus.fetch_req_i || fetch_gnt) begin
            burst_cnt_d = 4'd0;
        end else if (load_gnt && (burst_cnt_q != 4'hF)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
        addr_err_d = addr_err_q || (fetch_gnt && !fetch_legal) || (load_gnt && !load_legal);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_owner_q   <= RSP_NONE;
            rsp_illegal_q <= 1'b0;
            rsp_we_q      <= 1'b0;
            burst_cnt_q   <= 4'd0;
            addr_err_q    <= 1'b0;
        end else begin
            rsp_owner_q   <= rsp_owner_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_we_q      <= rsp_we_d;
            burst_cnt_q   <= burst_cnt_d;
            addr_err_q    <= addr_err_d;
        end
    end

    always_comb begin
        bus.fetch_rvalid_o = (rsp_owner_q == RSP_FETCH);
        bus.load_rvalid_o  = (rsp_owner_q == RSP_LOAD);
        bus.fetch_rdata_o  = '0;
        bus.load_rdata_o   = '0;
        if (rsp_owner_q == RSP_FETCH) begin
            bus.fetch_rdata_o = rsp_illegal_q ? NOP_WORD : bus.mem_rdata_i;
        end
        // Write acknowledges and illegal loader reads both return zero.
        if ((rsp_owner_q == RSP_LOAD) && !rsp_we_q && !rsp_illegal_q) begin
            bus.load_rdata_o = bus.mem_rdata_i;
        end
        bus.addr_err_o = addr_err_q;
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_stall_o <= 32'd0;
            perf_load_gnt_o    <= 32'd0;
        end else begin
            if (bus.fetch_req_i && !fetch_gnt && (perf_fetch_stall_o != 32'hFFFF_FFFF)) begin
                perf_fetch_stall_o <= perf_fetch_stall_o + 32'd1;
            end
            if (load_gnt && (perf_load_gnt_o != 32'hFFFF_FFFF)) begin
                perf_load_gnt_o <= perf_load_gnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_program_memory_arbiter.sv
// tb/tb_program_memory_arbiter.sv - scoreboard bench for program_memory_arbiter
// Define ARB_PERF_CNT_EN for both files to exercise the performance counters.
module tb_program_memory_arbiter;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t fq[$];
    exp_t lq[$];
    logic [31:0] mem [32];

    program_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_W(5)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_fetch_stall;
    logic [31:0] perf_load_gnt;
`endif

    program_memory_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_fetch_stall_o (perf_fetch_stall),
        .perf_load_gnt_o    (perf_load_gnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] img(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Synchronous-read program memory.
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              bus.mem_rdata_i <= mem[bus.mem_addr_o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.fetch_rvalid_o) begin
                if (fq.size() == 0) check("fetch_spurious_rvalid", 32'(bus.fetch_rvalid_o), 32'd0);
                else begin
                    e = fq.pop_front();
                    check("fetch_rdata", bus.fetch_rdata_o, e.data);
                    check("fetch_latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end
            if (bus.load_rvalid_o) begin
                if (lq.size() == 0) check("load_spurious_rvalid", 32'(bus.load_rvalid_o), 32'd0);
                else begin
                    e = lq.pop_front();
                    check("load_rdata", bus.load_rdata_o, e.data);
                    check("load_latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end
        end
    end

    task automatic push_f(input logic [31:0] d);
        exp_t e;
        e.data = d; e.cyc = cyc;
        fq.push_back(e);
    endtask

    task automatic push_l(input logic [31:0] d);
        exp_t e;
        e.data = d; e.cyc = cyc;
        lq.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp,
                            input logic exp_en, input logic [31:0] exp_idx);
        int n;
        n = 0;
        bus.fetch_req_i  = 1'b1;
        bus.fetch_addr_i = addr;
        @(negedge clk);
        while (!bus.fetch_gnt_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.fetch_gnt_o) check("fetch_gnt_timeout", 32'd0, 32'd1);
        else begin
            push_f(exp);
            check("fetch_mem_en", 32'(bus.mem_en_o), 32'(exp_en));
            if (exp_en) check("fetch_mem_addr", 32'(bus.mem_addr_o), exp_idx);
        end
        @(posedge clk); #1;
        bus.fetch_req_i = 1'b0;
    endtask

    task automatic do_load(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp, input logic exp_en, input logic [31:0] exp_idx);
        int n;
        n = 0;
        bus.load_req_i   = 1'b1;
        bus.load_we_i    = we;
        bus.load_addr_i  = addr;
        bus.load_wdata_i = wdata;
        @(negedge clk);
        while (!bus.load_gnt_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.load_gnt_o) check("load_gnt_timeout", 32'd0, 32'd1);
        else begin
            push_l(exp);
            check("load_mem_en", 32'(bus.mem_en_o), 32'(exp_en));
            check("load_mem_we", 32'(bus.mem_we_o), 32'(exp_en && we));
            if (exp_en) check("load_mem_addr", 32'(bus.mem_addr_o), exp_idx);
            if (exp_en && we) check("load_mem_wdata", bus.mem_wdata_o, wdata);
        end
        @(posedge clk); #1;
        bus.load_req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fw;
        for (int i = 0; i < 32; i++) mem[i] = img(i);
        bus.mem_rdata_i  = '0;
        bus.fetch_req_i  = 1'b0;
        bus.fetch_addr_i = '0;
        bus.load_req_i   = 1'b0;
        bus.load_we_i    = 1'b0;
        bus.load_addr_i  = '0;
        bus.load_wdata_i = '0;

        // Reset state
        #2;
        check("rst_fetch_gnt", 32'(bus.fetch_gnt_o), 32'd0);
        check("rst_fetch_rvalid", 32'(bus.fetch_rvalid_o), 32'd0);
        check("rst_load_rvalid", 32'(bus.load_rvalid_o), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
        check("rst_addr_err", 32'(bus.addr_err_o), 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);

        // Contention: L,L,L,L,F repeating for 20 cycles
        bus.fetch_req_i  = 1'b1;
        bus.fetch_addr_i = TEXT_BASE + 32'h4;
        bus.load_req_i   = 1'b1;
        bus.load_we_i    = 1'b0;
        bus.load_addr_i  = TEXT_BASE + 32'h10;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            fw = (k % 5 == 4);
            check("arb_fetch_gnt", 32'(bus.fetch_gnt_o), 32'(fw));
            check("arb_load_gnt", 32'(bus.load_gnt_o), 32'(!fw));
            if (fw) push_f(img(1));
            else    push_l(img(4));
            @(posedge clk); #1;
        end
        bus.fetch_req_i = 1'b0;
        bus.load_req_i  = 1'b0;
`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        check("perf_load_gnt", perf_load_gnt, 32'd16);
        check("perf_fetch_stall", perf_fetch_stall, 32'd16);
`endif
        idle(2);

        // Fetch-only stream, one grant per cycle
        for (int i = 0; i < 8; i++) do_fetch(TEXT_BASE + 32'(4 * i), img(i), 1'b1, 32'(i));
        idle(2);

        // Loader write then fetch and loader read of the same word
        do_load(1'b1, 32'h0040_0008, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'd2);
        do_fetch(32'h0040_0008, 32'hDEAD_BEEF, 1'b1, 32'd2);
        do_load(1'b0, 32'h0040_0008, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'd2);
        do_fetch(32'h0040_007C, img(31), 1'b1, 32'd31);
        idle(2);

        // Illegal addresses
        check("addr_err_clear", 32'(bus.addr_err_o), 32'd0);
        do_fetch(32'h0040_0002, NOP_WORD, 1'b0, 32'd0);
        @(negedge clk);
        check("addr_err_set", 32'(bus.addr_err_o), 32'd1);
        idle(1);
        do_fetch(32'h003F_FFFC, NOP_WORD, 1'b0, 32'd0);
        do_fetch(32'h0040_0080, NOP_WORD, 1'b0, 32'd0);
        do_load(1'b0, 32'h0040_0081, 32'd0, 32'd0, 1'b0, 32'd0);
        do_load(1'b1, 32'h0040_0080, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0);
        idle(2);
        check("addr_err_sticky", 32'(bus.addr_err_o), 32'd1);

        // Reset in the grant cycle of a fetch
        bus.fetch_req_i  = 1'b1;
        bus.fetch_addr_i = TEXT_BASE + 32'h10;
        @(negedge clk);
        check("r5_fetch_gnt", 32'(bus.fetch_gnt_o), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("r5_gnt_gated", 32'(bus.fetch_gnt_o), 32'd0);
        check("r5_mem_en", 32'(bus.mem_en_o), 32'd0);
        check("r5_addr_err", 32'(bus.addr_err_o), 32'd0);
        check("r5_fetch_rdata", bus.fetch_rdata_o, 32'd0);
        bus.fetch_req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("r5_no_rvalid", 32'(bus.fetch_rvalid_o), 32'd0);
        idle(1);
        do_fetch(TEXT_BASE + 32'h14, img(5), 1'b1, 32'd5);

        // Reset in the grant cycle of a write: memory must be untouched
        bus.load_req_i   = 1'b1;
        bus.load_we_i    = 1'b1;
        bus.load_addr_i  = TEXT_BASE + 32'hC;
        bus.load_wdata_i = 32'h1234_5678;
        @(negedge clk);
        check("r5_load_gnt", 32'(bus.load_gnt_o), 32'd1);
        #1 reset = 1'b0;
        bus.load_req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("r5_no_load_rvalid", 32'(bus.load_rvalid_o), 32'd0);
        idle(1);
        do_fetch(TEXT_BASE + 32'hC, img(3), 1'b1, 32'd3);
        idle(3);

        check("fetch_queue_drained", 32'(fq.size()), 32'd0);
        check("load_queue_drained", 32'(lq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
